lab5_cnt_ctrl: RTL and testbench

Upstream driver for the birth-digit decoder and 7-segment stage. Produces the 3-bit index `cnt` (0..7) that the decoder converts to a displayed digit.
- Free-running mode: `cnt` steps once per divided time base.
- Stopped mode: `cnt` steps once per debounced button press.
- Handles raw board buttons and switch: synchronisation, debouncing, run/stop FSM, clock division and up/down wrap counting.

---
 rtl/lab5_cnt_ctrl.sv | 147 ++++++++++++++
 tb/tb_lab5_cnt_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lab5_cnt_ctrl.sv
// lab5_cnt_ctrl: 3-bit up/down index generator for the birth-digit decoder.
// Synchronises and debounces raw buttons, runs a run/stop FSM and a time-base divider.
//
// Ports:
//   clk      - system clock, rising edge
//   rst      - asynchronous active-low reset
//   btn_run  - raw run/stop button (active-high, bouncy, asynchronous)
//   btn_step - raw single-step button (active-high, bouncy, asynchronous)
//   sw_dir   - raw direction switch, 1 = up, 0 = down
//   cnt      - current index 0..7
//   running  - high while in RUN
//   tick     - one-cycle pulse in the cycle cnt first shows a new value
module lab5_cnt_ctrl #(
    parameter int DIV_MAX   = 49_999_999,
    parameter int DB_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_run,
    input  logic       btn_step,
    input  logic       sw_dir,
    output logic [2:0] cnt,
    output logic       running,
    output logic       tick
);

    localparam int DIV_W = (DIV_MAX > 0) ? $clog2(DIV_MAX + 1) : 1;
    localparam int DB_W  = $clog2(DB_CYCLES + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_MAX);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DB_CYCLES - 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    // bit 0 = run, bit 1 = step, bit 2 = dir
    logic [2:0] sync1;
    logic [2:0] sync2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {sw_dir, btn_step, btn_run};
            sync2 <= sync1;
        end
    end

    // Debounce: db follows sync only after DB_CYCLES consecutive
    // disagreeing cycles; any agreeing cycle restarts the count.
    logic [1:0]      db;
    logic [1:0]      db_prev;
    logic [1:0]      press;
    logic [DB_W-1:0] db_cnt [2];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            db      <= '0;
            db_prev <= '0;
            press   <= '0;
            for (int i = 0; i < 2; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            db_prev <= db;
            press   <= db & ~db_prev;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == db[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    db[i]     <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    logic run_p;
    logic step_p;
    logic dir;

    assign run_p  = press[0];
    assign step_p = press[1];
    assign dir    = sync2[2];

    logic [0:0]       state;
    logic [0:0]       state_nxt;
    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] div_nxt;
    logic             adv;
    logic             div_hit;

    assign div_hit = (div == DIV_LAST);

    // A run press in IDLE swallows a simultaneous step press.
    // A run press on the divider's terminal cycle still lets that
    // advance happen before stopping.
    always_comb begin
        state_nxt = state;
        div_nxt   = div;
        adv       = 1'b0;
        unique case (state)
            S_IDLE: begin
                div_nxt = '0;
                if (run_p) begin
                    state_nxt = S_RUN;
                end else if (step_p) begin
                    adv = 1'b1;
                end
            end
            S_RUN: begin
                if (div_hit) begin
                    div_nxt = '0;
                    adv     = 1'b1;
                end else begin
                    div_nxt = div + DIV_W'(1);
                end
                if (run_p) begin
                    state_nxt = S_IDLE;
                    div_nxt   = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            running <= 1'b0;
            div     <= '0;
            cnt     <= '0;
            tick    <= 1'b0;
        end else begin
            state   <= state_nxt;
            running <= (state_nxt == S_RUN);
            div     <= div_nxt;
            tick    <= adv;
            if (adv) begin
                cnt <= dir ? cnt + 3'd1 : cnt - 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_lab5_cnt_ctrl.sv
// tb_lab5_cnt_ctrl: directed and random stimulus for lab5_cnt_ctrl,
// checked against a behavioural model of the button/run/stop rules.
module tb_lab5_cnt_ctrl;

    localparam int DIV_MAX = 3;
    localparam int DB      = 4;
    localparam int PER     = DIV_MAX + 1;

    logic clk      = 1'b0;
    logic rst      = 1'b0;
    logic btn_run  = 1'b0;
    logic btn_step = 1'b0;
    logic sw_dir   = 1'b0;
    wire [2:0] cnt;
    wire       running;
    wire       tick;

    lab5_cnt_ctrl #(
        .DIV_MAX  (DIV_MAX),
        .DB_CYCLES(DB)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .btn_run (btn_run),
        .btn_step(btn_step),
        .sw_dir  (sw_dir),
        .cnt     (cnt),
        .running (running),
        .tick    (tick)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: raw inputs seen two edges late, a level is accepted once the
    // last DB delayed samples all disagree with it, a press acts two edges
    // after its level rose, and RUN advances every PER edges from entry.
    logic [2:0] m_raw  [$];
    logic [1:0] m_sync [$];
    int         m_k;
    int         m_start;
    int         m_cnt;
    bit         m_run;
    bit         m_tick;
    bit   [1:0] m_db;
    bit   [1:0] m_rose1;
    bit   [1:0] m_rose2;

    task automatic chk(input string tag, input logic [31:0] obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_raw   = {};
        m_sync  = {};
        m_k     = 0;
        m_start = 0;
        m_cnt   = 0;
        m_run   = 1'b0;
        m_tick  = 1'b0;
        m_db    = '0;
        m_rose1 = '0;
        m_rose2 = '0;
    endtask

    task automatic m_step(input logic [2:0] v);
        logic [2:0] s;
        bit   [1:0] rose;
        bit   [1:0] pr;
        bit         all;
        s = (m_raw.size() == 2) ? m_raw[0] : 3'b000;
        m_raw.push_back(v);
        if (m_raw.size() > 2) void'(m_raw.pop_front());
        m_sync.push_back(s[1:0]);
        if (m_sync.size() > DB) void'(m_sync.pop_front());
        m_k++;
        rose = '0;
        for (int b = 0; b < 2; b++) begin
            if (m_sync.size() == DB) begin
                all = 1'b1;
                foreach (m_sync[j]) begin
                    if (m_sync[j][b] == m_db[b]) all = 1'b0;
                end
                if (all) begin
                    m_db[b] = ~m_db[b];
                    rose[b] = m_db[b];
                end
            end
        end
        pr      = m_rose2;
        m_rose2 = m_rose1;
        m_rose1 = rose;
        m_tick  = 1'b0;
        if (m_run) begin
            if ((m_k - m_start) % PER == 0) m_tick = 1'b1;
            if (pr[0]) m_run = 1'b0;
        end else if (pr[0]) begin
            m_run   = 1'b1;
            m_start = m_k;
        end else if (pr[1]) begin
            m_tick = 1'b1;
        end
        if (m_tick) m_cnt = s[2] ? (m_cnt + 1) % 8 : (m_cnt + 7) % 8;
    endtask

    task automatic step(input bit r, input bit s, input bit d);
        btn_run  = r;
        btn_step = s;
        sw_dir   = d;
        @(posedge clk);
        m_step({d, s, r});
        @(negedge clk);
        chk("cnt", cnt, m_cnt);
        chk("running", running, m_run);
        chk("tick", tick, m_tick);
    endtask

    task automatic press(input bit r, input bit s, input bit d);
        repeat (6) step(r, s, d);
        repeat (8) step(1'b0, 1'b0, d);
    endtask

    initial begin
        int ticks;
        int exp_c;
        int seg;
        bit rr, ss, dd;

        // Reset held with buttons toggling
        m_reset();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            btn_run  = 1'($urandom);
            btn_step = 1'($urandom);
            sw_dir   = 1'($urandom);
            @(negedge clk);
            chk("rst_cnt", cnt, 0);
            chk("rst_running", running, 0);
            chk("rst_tick", tick, 0);
        end
        btn_run  = 1'b0;
        btn_step = 1'b0;
        sw_dir   = 1'b0;
        rst      = 1'b1;
        repeat (50) step(1'b0, 1'b0, 1'b0);
        chk("idle50_cnt", cnt, 0);

        // Step latency: change lands exactly on E0+7
        repeat (4) step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 1'b1);
            chk("lat_cnt", cnt, (i == 7) ? 1 : 0);
            chk("lat_tick", tick, (i == 7) ? 1 : 0);
        end
        repeat (12) step(1'b0, 1'b0, 1'b1);

        // Short glitches are rejected
        repeat (2) begin
            repeat (3) step(1'b0, 1'b1, 1'b1);
            repeat (6) step(1'b0, 1'b0, 1'b1);
        end
        chk("glitch_cnt", cnt, 1);

        // Seven clean presses walk 2..7 then wrap to 0
        for (int p = 0; p < 7; p++) begin
            press(1'b0, 1'b1, 1'b1);
            chk("walk_cnt", cnt, (2 + p) % 8);
        end

        // Down wrap 0 -> 7 -> 6
        repeat (3) step(1'b0, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        chk("down_wrap", cnt, 7);
        press(1'b0, 1'b1, 1'b0);
        chk("down_step", cnt, 6);

        // Run mode, step presses ignored
        repeat (3) step(1'b0, 1'b0, 1'b1);
        press(1'b1, 1'b0, 1'b1);
        chk("run_on", running, 1);
        ticks = 0;
        for (int i = 0; i < 32; i++) begin
            step(1'b0, (i < 20) && ((i % 10) < 6), 1'b1);
            ticks += int'(tick);
        end
        chk("run_ticks", ticks, 8);

        // Stop press landing on the divider's terminal cycle
        for (int i = 0; i < PER; i++) begin
            if ((m_k + 8 - m_start) % PER != 0) step(1'b0, 1'b0, 1'b1);
        end
        for (int i = 0; i < 8; i++) begin
            step(i < 6, 1'b0, 1'b1);
        end
        chk("coll_tick", tick, 1);
        chk("coll_running", running, 0);
        ticks = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b0, 1'b1);
            ticks += int'(tick);
        end
        chk("coll_quiet", ticks, 0);
        chk("coll_stopped", running, 0);

        // Random bursts against the model
        for (int n = 0; n < 250; n++) begin
            rr  = 1'($urandom);
            ss  = 1'($urandom);
            dd  = 1'($urandom);
            seg = int'($urandom_range(1, 12));
            repeat (seg) step(rr, ss, dd);
        end
        repeat (12) step(1'b0, 1'b0, 1'b1);
        if (m_run) press(1'b1, 1'b0, 1'b1);
        repeat (4) step(1'b0, 1'b0, 1'b1);

        // Simultaneous run + step in IDLE
        exp_c = m_cnt;
        for (int i = 0; i < 12; i++) begin
            step(i < 6, i < 6, 1'b1);
            if (i == 7) begin
                chk("sim_running", running, 1);
                chk("sim_cnt", cnt, exp_c);
            end
            if (i >= 7 && i <= 10) chk("sim_notick", tick, 0);
        end
        chk("sim_tick", tick, 1);
        chk("sim_adv", cnt, (exp_c + 1) % 8);
        repeat (5) step(1'b0, 1'b0, 1'b1);

        // Reset mid-RUN takes effect without a clock edge
        rst = 1'b0;
        #1;
        chk("mid_rst_cnt", cnt, 0);
        chk("mid_rst_running", running, 0);
        chk("mid_rst_tick", tick, 0);
        m_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (10) step(1'b0, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
